// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared types for the branch predictor state
// Purpose: BTB entry layout, predictor FSM states and counter type.
// Ports: none (package).
package rv32i_types;

  localparam int BTB_IDX_BITS = 5;
  localparam int BTB_TAG_BITS = 32 - BTB_IDX_BITS - 2;

  typedef logic [1:0] ctr_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } pred_state_t;

  typedef struct packed {
    logic                    valid;
    logic [BTB_TAG_BITS-1:0] tag;
    logic [31:0]             target;
    ctr_t                    ctr;
    logic                    is_jump;
  } btb_entry_t;

endpackage

// File: rtl/sat_counter2.sv
// rtl/sat_counter2.sv - next value of a 2-bit saturating direction counter
// Purpose: taken counts up, not-taken counts down, 2'b00 and 2'b11 hold.
// Ports:
//   ctr      in  2  current counter value
//   taken    in  1  resolved direction
//   ctr_next out 2  updated counter value
module sat_counter2
  import rv32i_types::*;
(
  input  ctr_t ctr,
  input  logic taken,
  output ctr_t ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != 2'b11) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != 2'b00) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor_ctrl.sv
// rtl/branch_predictor_ctrl.sv - BTB plus 2-bit direction counters for IF-stage prediction
// Purpose: combinational lookup on the fetch PC, single write port for EX-stage
// resolved branches/jumps, and an init sweep that invalidates one entry per cycle
// after reset or flush.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             invalidate whole table (restart the init sweep)
//   if_pc             fetch PC to look up
//   pred_hit/pred_taken/pred_target  lookup result (all 0 while not ready)
//   ready             table usable (RUN state)
//   upd_valid/upd_pc/upd_is_jump/upd_taken/upd_target  EX-stage update port
// IDX_BITS must equal BTB_IDX_BITS so the entry tag width matches.
module branch_predictor_ctrl
  import rv32i_types::*;
#(
  parameter int IDX_BITS = BTB_IDX_BITS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [31:0] if_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic        ready,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_is_jump,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);

  localparam int ENTRIES = 2 ** IDX_BITS;

  pred_state_t         state;
  logic [IDX_BITS-1:0] sweep_cnt;
  btb_entry_t          btb_q [ENTRIES];

  logic [IDX_BITS-1:0] lk_idx;
  logic [IDX_BITS-1:0] up_idx;
  btb_entry_t          lk_entry;
  btb_entry_t          up_entry;
  logic                lk_hit;
  logic                up_hit;
  ctr_t                ctr_next;

  // Byte-offset bits of word-aligned PCs carry no information here.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{if_pc[1:0], upd_pc[1:0]};

  // Init sweep: counter wraps from all-ones back to zero as RUN is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      sweep_cnt <= '0;
    end else if (flush) begin
      state     <= INIT;
      sweep_cnt <= '0;
    end else if (state == INIT) begin
      sweep_cnt <= sweep_cnt + IDX_BITS'(1);
      if (sweep_cnt == '1) state <= RUN;
    end
  end

  assign lk_idx   = if_pc[IDX_BITS+1:2];
  assign up_idx   = upd_pc[IDX_BITS+1:2];
  assign lk_entry = btb_q[lk_idx];
  assign up_entry = btb_q[up_idx];

  assign lk_hit = (state == RUN) && lk_entry.valid && (lk_entry.tag == if_pc[31:IDX_BITS+2]);
  assign up_hit = up_entry.valid && (up_entry.tag == upd_pc[31:IDX_BITS+2]);

  sat_counter2 u_sat_counter2 (
    .ctr      (up_entry.ctr),
    .taken    (upd_taken),
    .ctr_next (ctr_next)
  );

  // Table storage has no reset: only valid bits are cleared, by the sweep.
  // Lookup reads the pre-edge contents, so a same-cycle update is not bypassed.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (state == INIT) begin
        btb_q[sweep_cnt].valid <= 1'b0;
      end else if (upd_valid) begin
        if (up_hit) begin
          btb_q[up_idx].ctr <= ctr_next;
          if (upd_taken) begin
            btb_q[up_idx].target  <= upd_target;
            btb_q[up_idx].is_jump <= upd_is_jump;
          end
        end else if (upd_taken) begin
          btb_q[up_idx].valid   <= 1'b1;
          btb_q[up_idx].tag     <= upd_pc[31:IDX_BITS+2];
          btb_q[up_idx].target  <= upd_target;
          btb_q[up_idx].ctr     <= 2'b10;
          btb_q[up_idx].is_jump <= upd_is_jump;
        end
      end
    end
  end

  assign ready       = (state == RUN);
  assign pred_hit    = lk_hit;
  assign pred_taken  = lk_hit && (lk_entry.is_jump || lk_entry.ctr[1]);
  assign pred_target = lk_hit ? lk_entry.target : 32'h0;

endmodule
